// File: rtl/io_port_responder.sv
// Bus responder with a 4-register window and a transmit FIFO drained onto a
// valid/ready stream. Bus outputs stay 0 unless a hit is being answered.
module io_port_responder #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          RESP_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        request_flag,
    input  logic        mode_flag,
    input  logic [15:0] locator,
    input  logic [15:0] write_bus,
    output logic [15:0] read_bus,
    output logic        response_flag,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND, RELEASE} state_t;

    state_t          state_q;
    logic [3:0]      lat_q;
    logic [15:0]     rdata_q;
    logic [15:0]     read_bus_q;
    logic            resp_q;
    logic [15:0]     scratch_q;
    logic            enable_q;
    logic            overflow_q;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      count_q, count_d;
    logic [15:0]     mem_q [FIFO_DEPTH];

    logic            hit, accept, full, empty, push, push_ok, pop;
    logic [1:0]      idx;
    logic [15:0]     rd_value;

    assign hit     = (locator[15:2] == BASE_ADDR[15:2]);
    assign idx     = locator[1:0];
    assign accept  = (state_q == IDLE) && request_flag && hit;
    assign full    = (count_q == 8'(FIFO_DEPTH));
    assign empty   = (count_q == 8'd0);
    assign push    = accept && mode_flag && (idx == 2'd0);
    // Fullness is judged before the edge; a simultaneous pop does not make room.
    assign push_ok = push && !full;
    assign pop     = out_valid && out_ready;

    assign out_valid     = !empty && enable_q;
    assign out_data      = empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign read_bus      = read_bus_q;
    assign response_flag = resp_q;

    always_comb begin
        case (idx)
            2'd1:    rd_value = {overflow_q, full, empty, 5'b0, count_q};
            2'd2:    rd_value = scratch_q;
            2'd3:    rd_value = {15'b0, enable_q};
            default: rd_value = 16'h0000;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok)
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        count_d = count_q + 8'(push_ok) - 8'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_q      <= 4'd0;
            rdata_q    <= 16'h0000;
            read_bus_q <= 16'h0000;
            resp_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= BUSY;
                        lat_q   <= 4'(RESP_LATENCY - 1);
                        rdata_q <= mode_flag ? 16'h0000 : rd_value;
                    end
                end
                BUSY: begin
                    if (lat_q == 4'd0) begin
                        state_q    <= RESPOND;
                        resp_q     <= 1'b1;
                        read_bus_q <= rdata_q;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                RESPOND: begin
                    state_q    <= RELEASE;
                    resp_q     <= 1'b0;
                    read_bus_q <= 16'h0000;
                end
                RELEASE: begin
                    // A request still held from the finished transaction is never re-accepted.
                    if (!request_flag)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch_q  <= 16'h0000;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 8'd0;
        end else begin
            if (accept && mode_flag) begin
                case (idx)
                    2'd1:    if (write_bus[15]) overflow_q <= 1'b0;
                    2'd2:    scratch_q <= write_bus;
                    2'd3:    enable_q  <= write_bus[0];
                    default: ;
                endcase
            end
            if (push && full)
                overflow_q <= 1'b1;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= write_bus;
    end

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_io_port_responder;
    localparam logic [15:0] BASE  = 16'hFF00;
    localparam int          DEPTH = 8;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        request_flag = 1'b0;
    logic        mode_flag = 1'b0;
    logic [15:0] locator = 16'h0000;
    logic [15:0] write_bus = 16'h0000;
    logic        out_ready = 1'b0;
    logic [15:0] read_bus, out_data;
    logic        response_flag, out_valid;

    int checks = 0;
    int errors = 0;

    io_port_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .RESP_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .request_flag(request_flag), .mode_flag(mode_flag),
        .locator(locator), .write_bus(write_bus), .read_bus(read_bus),
        .response_flag(response_flag), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, transactions tracked by edge numbers.
    bit [15:0] mq[$];
    bit        m_en, m_ovf;
    bit [15:0] m_scr;
    int        m_edge = 0;
    int        m_resp_edge = -100;
    bit        m_inflight;
    bit [15:0] m_resp_val;
    bit        m_pop, m_full, m_push;
    bit [15:0] m_push_data;
    bit [15:0] exp_rd, exp_data;
    bit        exp_resp, exp_valid;

    function automatic bit [15:0] m_read(input bit [1:0] i);
        case (i)
            2'd1:    return {m_ovf, (mq.size() == DEPTH), (mq.size() == 0), 5'b0, 8'(mq.size())};
            2'd2:    return m_scr;
            2'd3:    return {15'b0, m_en};
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_en = 0; m_ovf = 0; m_scr = 0;
            m_inflight = 0; m_resp_edge = -100; m_resp_val = 0;
            exp_rd = 0; exp_data = 0; exp_resp = 0; exp_valid = 0;
        end else begin
            m_edge++;
            m_pop  = exp_valid && out_ready;
            m_full = (mq.size() == DEPTH);
            m_push = 0;
            if (!m_inflight) begin
                if (request_flag && locator[15:2] == BASE[15:2]) begin
                    m_inflight  = 1;
                    m_resp_edge = m_edge + LAT;
                    if (mode_flag) begin
                        m_resp_val = 0;
                        case (locator[1:0])
                            2'd0: if (m_full) m_ovf = 1; else begin m_push = 1; m_push_data = write_bus; end
                            2'd1: if (write_bus[15]) m_ovf = 0;
                            2'd2: m_scr = write_bus;
                            default: m_en = write_bus[0];
                        endcase
                    end else begin
                        m_resp_val = m_read(locator[1:0]);
                    end
                end
            end else if (m_edge >= m_resp_edge + 2 && !request_flag) begin
                m_inflight = 0;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(m_push_data);
            exp_resp  = (m_edge == m_resp_edge);
            exp_rd    = exp_resp ? m_resp_val : 16'h0000;
            exp_valid = m_en && (mq.size() > 0);
            exp_data  = (mq.size() > 0) ? mq[0] : 16'h0000;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("response_flag", 32'(response_flag), 32'(exp_resp));
            chk("read_bus", 32'(read_bus), 32'(exp_rd));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("out_data", 32'(out_data), 32'(exp_data));
        end
    end

    // Stream collector and out_ready driver.
    bit [15:0] got[$];
    int        got_t[$];
    int        cyc = 0;
    bit        rand_rdy = 0;
    bit        rdy_fixed = 0;
    always @(posedge clk) begin
        cyc++;
        if (!reset && out_valid && out_ready) begin
            got.push_back(out_data);
            got_t.push_back(cyc);
        end
    end
    always @(negedge clk) out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;

    task automatic bus(input bit m, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output int lat);
        @(negedge clk);
        request_flag = 1; mode_flag = m; locator = a; write_bus = d;
        lat = -1; rd = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (response_flag) begin lat = n - 1; rd = read_bus; break; end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL bus_timeout: no response for locator %h", a);
        end
        request_flag = 0; mode_flag = 0; locator = 0; write_bus = 0;
        repeat (2) @(negedge clk);
    endtask

    logic [15:0] rd;
    int          lat, pulses, nz;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset_response", 32'(response_flag), 0);
        chk("reset_read_bus", 32'(read_bus), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", 32'(out_data), 0);
        @(negedge clk);
        reset = 0;
        cmp_en = 1;

        // SCRATCH write/read with latency
        bus(1, 16'hFF02, 16'hBEEF, rd, lat);
        chk("wr_scratch_lat", 32'(lat), 2);
        chk("wr_scratch_rd", 32'(rd), 0);
        bus(0, 16'hFF02, 16'h0000, rd, lat);
        chk("rd_scratch_lat", 32'(lat), 2);
        chk("rd_scratch_val", 32'(rd), 32'h0000BEEF);

        // Miss
        @(negedge clk);
        request_flag = 1; mode_flag = 0; locator = 16'h0010;
        pulses = 0; nz = 0;
        repeat (20) begin
            @(negedge clk);
            if (response_flag) pulses++;
            if (read_bus != 0) nz++;
        end
        request_flag = 0; locator = 0;
        chk("miss_pulses", 32'(pulses), 0);
        chk("miss_read_bus", 32'(nz), 0);

        // Stream ordering
        rdy_fixed = 0;
        bus(1, 16'hFF03, 16'h0000, rd, lat);
        for (int i = 1; i <= 3; i++) bus(1, 16'hFF00, 16'(i), rd, lat);
        bus(0, 16'hFF01, 16'h0000, rd, lat);
        chk("status_3", 32'(rd), 32'h0003);
        got.delete(); got_t.delete();
        rdy_fixed = 1;
        bus(1, 16'hFF03, 16'h0001, rd, lat);
        repeat (3) @(negedge clk);
        chk("drain_count", 32'(got.size()), 3);
        if (got.size() == 3) begin
            chk("drain_w0", 32'(got[0]), 1);
            chk("drain_w1", 32'(got[1]), 2);
            chk("drain_w2", 32'(got[2]), 3);
            chk("drain_consecutive", 32'(got_t[2] - got_t[0]), 2);
        end
        bus(0, 16'hFF01, 16'h0000, rd, lat);
        chk("status_empty", 32'(rd), 32'h2000);

        // Overflow
        rdy_fixed = 0;
        bus(1, 16'hFF03, 16'h0000, rd, lat);
        for (int i = 0; i < 9; i++) bus(1, 16'hFF00, 16'(10 + i), rd, lat);
        bus(0, 16'hFF01, 16'h0000, rd, lat);
        chk("status_ovf_full", 32'(rd), 32'hC008);
        bus(1, 16'hFF01, 16'h8000, rd, lat);
        bus(0, 16'hFF01, 16'h0000, rd, lat);
        chk("status_ovf_clr", 32'(rd), 32'h4008);
        got.delete(); got_t.delete();
        rdy_fixed = 1;
        bus(1, 16'hFF03, 16'h0001, rd, lat);
        repeat (10) @(negedge clk);
        chk("ovf_drain_count", 32'(got.size()), 8);
        if (got.size() == 8) begin
            chk("ovf_first", 32'(got[0]), 10);
            chk("ovf_last", 32'(got[7]), 17);
        end
        bus(0, 16'hFF01, 16'h0000, rd, lat);
        chk("status_after_ovf", 32'(rd), 32'h2000);

        // Held request gives a single response
        @(negedge clk);
        request_flag = 1; mode_flag = 0; locator = 16'hFF02;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (response_flag) pulses++;
        end
        request_flag = 0; locator = 0;
        chk("held_pulses", 32'(pulses), 1);
        repeat (2) @(negedge clk);
        bus(0, 16'hFF02, 16'h0000, rd, lat);
        chk("reassert_lat", 32'(lat), 2);

        // Reset in BUSY, request held through release
        rdy_fixed = 0;
        bus(1, 16'hFF00, 16'h0077, rd, lat);
        @(negedge clk);
        request_flag = 1; mode_flag = 1; locator = 16'hFF02; write_bus = 16'h5A5A;
        @(posedge clk);
        #2;
        reset = 1;
        #1;
        chk("rst_busy_response", 32'(response_flag), 0);
        chk("rst_busy_read_bus", 32'(read_bus), 0);
        chk("rst_busy_out_valid", 32'(out_valid), 0);
        chk("rst_busy_out_data", 32'(out_data), 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_response", 32'(response_flag), 0);
        reset = 0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (response_flag) begin lat = n - 1; break; end
        end
        chk("post_reset_lat", 32'(lat), 2);
        request_flag = 0; mode_flag = 0; locator = 0; write_bus = 0;
        repeat (2) @(negedge clk);
        bus(0, 16'hFF02, 16'h0000, rd, lat);
        chk("reexec_scratch", 32'(rd), 32'h5A5A);

        // Randomized traffic
        rand_rdy = 1;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                request_flag = 1; mode_flag = 1'($urandom_range(0, 1));
                locator = 16'($urandom_range(0, 16'hFEFF)); write_bus = 16'($urandom);
                repeat (3) @(negedge clk);
                request_flag = 0; locator = 0;
            end else begin
                bus(1'($urandom_range(0, 1)), BASE + 16'($urandom_range(0, 3)),
                    16'($urandom), rd, lat);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rand_rdy = 0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
